eth_tx_sched: RTL and testbench
===============================

Name: eth_tx_sched

Overview:
- Transmit scheduler in front of the single Ethernet frame sender (GMII byte serialiser with preamble/MAC/type/FIFO payload/FCS sequencing).
- Arbitrates two frame sources, ARP reply (port 0) and ARP request (port 1, external or internal periodic timer), round-robin.
- Loads the winner's target MAC, frame type and payload length, pulses the sender's start strobe, then tracks the sender's gmii_tx_en to detect frame end.
- Enforces an inter-frame gap before the next launch.

Parameters:
IFG_CYCLES, 12, idle cycles after gmii_tx_en falls before the next launch (min 1)
START_TIMEOUT, 64, cycles to wait for gmii_tx_en to rise after launch before aborting
PERIOD_CYCLES, 125000000, interval of internal ARP-request trigger; 0 disables timer
CNT_W, 32, width of the period/timeout/IFG counters

Ports:
gmii_tx_clk  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
sched_en  in  1  1 = arbitration allowed; 0 = finish current frame, launch nothing new
req0  in  1  one-cycle request pulse, ARP reply
tgt_mac0  in  48  destination MAC for req0
type0  in  16  frame type for req0
len0  in  16  payload byte count for req0
req1  in  1  one-cycle request pulse, ARP request
tgt_mac1  in  48  destination MAC for req1
type1  in  16  frame type for req1
len1  in  16  payload byte count for req1
gmii_tx_en  in  1  sender's transmit enable, monitored only
tx_en  out  1  one-cycle start strobe to sender
target_mac_addr  out  48  latched destination MAC
frame_type  out  16  latched frame type
fifo_data_length  out  16  latched payload length
busy  out  1  1 in every state except IDLE
grant  out  1  index of current or last granted port
done  out  2  one-cycle pulse per port on frame completion
err  out  1  one-cycle pulse on start timeout

Behaviour:
- Reset: tx_en=0, target_mac_addr=0, frame_type=0, fifo_data_length=0, busy=0, grant=1 (port 0 wins first tie), done=0, err=0, pending=0, all counters=0, state=IDLE.
- pending[i] is set by req_i (pending[1] also by the timer) and cleared on the cycle port i is granted. Set and clear in the same cycle: set wins, so the request stays pending. Repeated requests while pending merge into one.
- Fields tgt_macN/typeN/lenN are sampled on the grant cycle, not on the req pulse.
- Timer: free-running counter 0..PERIOD_CYCLES-1. Sets pending[1] on the wrap cycle. Runs regardless of sched_en.
- FSM:
  - IDLE: when sched_en=1 and pending!=0, pick a port. If both are pending, take the port != grant; otherwise take the single pending port. Latch that port's fields into the outputs, update grant, clear its pending bit -> LAUNCH.
  - LAUNCH: tx_en=1 for exactly this cycle -> WAIT_START. Output fields stay stable from the grant cycle until the next grant.
  - WAIT_START: gmii_tx_en=1 -> WAIT_END. If START_TIMEOUT cycles elapse (counted from entry) without it, err=1 for one cycle -> IFG, no done.
  - WAIT_END: on the first cycle gmii_tx_en=0, done[grant]=1 for one cycle -> IFG.
  - IFG: count IFG_CYCLES cycles -> IDLE. Launch-to-launch minimum = frame + IFG_CYCLES + 2.
- sched_en dropping mid-frame does not abort; the FSM completes to IDLE and holds there.
- Reset asserted mid-frame: immediate return to reset values. Pending requests are lost.
- Lengths pass through unmodified; len 0/1 are legal, and a payload-free frame is the sender's responsibility.
- No combinational path from any input to tx_en or done.

Test Plan:
- Single req0 (mac 0x0011_2233_4455, type 0x0806, len 28), sched_en=1, gmii_tx_en modelled high 2 cycles after tx_en for 27 cycles -> tx_en one pulse 2 cycles after req0, outputs hold those values, done=2'b01 on the cycle gmii_tx_en is first seen low, busy low IFG_CYCLES+1 cycles later.
- req0 and req1 in the same cycle from reset -> port 0 served first, then port 1. Next launch tx_en ≥ IFG_CYCLES+2 cycles after the first frame ends. done 01 then 10.
- Back-to-back arbitration: req1 and req0 both pending with grant=1 -> port 0 granted. Port 1 re-requesting continuously -> grants alternate 0,1,0,1.
- gmii_tx_en held 0 after launch -> err pulse exactly START_TIMEOUT cycles after WAIT_START entry, no done, FSM returns to IDLE after the IFG.
- PERIOD_CYCLES=100 with sched_en=0 for 250 cycles, then 1 -> exactly one port-1 frame (merged), launched 2 cycles after sched_en rises.
- rst_n pulsed low during WAIT_END -> all outputs zero asynchronously, grant=1, no done, and a new req0 after release is served normally.

Source files
------------

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin scheduler for two ARP frame sources in front of a single GMII frame sender,
// with a start timeout, frame-end tracking and an enforced inter-frame gap.
module eth_tx_sched #(
  parameter int unsigned IFG_CYCLES    = 12,
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned PERIOD_CYCLES = 125000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        sched_en,
  input  logic        req0,
  input  logic [47:0] tgt_mac0,
  input  logic [15:0] type0,
  input  logic [15:0] len0,
  input  logic        req1,
  input  logic [47:0] tgt_mac1,
  input  logic [15:0] type1,
  input  logic [15:0] len1,
  input  logic        gmii_tx_en,
  output logic        tx_en,
  output logic [47:0] target_mac_addr,
  output logic [15:0] frame_type,
  output logic [15:0] fifo_data_length,
  output logic        busy,
  output logic        grant,
  output logic [1:0]  done,
  output logic        err
);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WSTART, S_WEND, S_IFG} state_t;
  localparam logic [CNT_W-1:0] P_LAST   = (PERIOD_CYCLES == 0) ? '0 : CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
  state_t            r_state;
  logic [CNT_W-1:0]  r_tmr, r_cnt;
  logic [1:0]        r_pend, r_done;
  logic              r_en, r_grant, r_tx_en, r_err;
  logic [47:0]       r_mac;
  logic [15:0]       r_type, r_len;
  logic              w_wrap, w_go, w_sel;
  logic [1:0]        w_set, w_clr;
  assign w_wrap = (PERIOD_CYCLES != 0) && (r_tmr == P_LAST);
  assign w_set  = {req1 | w_wrap, req0};
  // both pending: the port that did not win last time; otherwise the only one pending
  assign w_sel  = (r_pend == 2'b11) ? ~r_grant : r_pend[1];
  assign w_go   = (r_state == S_IDLE) && r_en && (r_pend != 2'b00);
  assign w_clr  = w_go ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_done  <= '0;
      r_en    <= 1'b0;
      r_grant <= 1'b1;
      r_tx_en <= 1'b0;
      r_err   <= 1'b0;
      r_mac   <= '0;
      r_type  <= '0;
      r_len   <= '0;
    end else begin
      r_en    <= sched_en;
      r_tmr   <= (w_wrap || PERIOD_CYCLES == 0) ? '0 : r_tmr + CNT_W'(1);
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_tx_en <= 1'b0;
      r_done  <= '0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: if (w_go) begin
          r_grant <= w_sel;
          r_mac   <= w_sel ? tgt_mac1 : tgt_mac0;
          r_type  <= w_sel ? type1 : type0;
          r_len   <= w_sel ? len1 : len0;
          r_tx_en <= 1'b1;
          r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_WSTART;
        end
        S_WSTART: if (gmii_tx_en) r_state <= S_WEND;
        else if (r_cnt == TO_LAST) begin
          r_err   <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_IFG;
        end else r_cnt <= r_cnt + CNT_W'(1);
        S_WEND: if (!gmii_tx_en) begin
          r_done  <= r_grant ? 2'b10 : 2'b01;
          r_cnt   <= '0;
          r_state <= S_IFG;
        end
        S_IFG: if (r_cnt == IFG_LAST) r_state <= S_IDLE;
        else r_cnt <= r_cnt + CNT_W'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign tx_en            = r_tx_en;
  assign target_mac_addr  = r_mac;
  assign frame_type       = r_type;
  assign fifo_data_length = r_len;
  assign busy             = (r_state != S_IDLE);
  assign grant            = r_grant;
  assign done             = r_done;
  assign err              = r_err;
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: randomized scoreboard bench; a timeline reference model predicts every launch,
// completion and timeout, and a monitor compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_eth_tx_sched;
  localparam int IFG = 12;
  localparam int TO  = 64;
  logic clk = 0, rst_n = 0, sched_en = 0, req0 = 0, req1 = 0, gmii = 0, t_en = 0;
  logic [47:0] mac0 = 0, mac1 = 0;
  logic [15:0] type0 = 0, type1 = 0, len0 = 0, len1 = 0;
  logic tx_en, busy, grant, err, t_tx_en, t_busy, t_grant, t_err;
  logic [1:0] done, t_done;
  logic [47:0] tmac, t_mac;
  logic [15:0] ftype, flen, t_type, t_len;
  always #4 clk = ~clk;

  eth_tx_sched #(.IFG_CYCLES(IFG), .START_TIMEOUT(TO), .PERIOD_CYCLES(0), .CNT_W(32)) u_dut (
    .gmii_tx_clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req0(req0), .tgt_mac0(mac0), .type0(type0), .len0(len0),
    .req1(req1), .tgt_mac1(mac1), .type1(type1), .len1(len1),
    .gmii_tx_en(gmii), .tx_en(tx_en), .target_mac_addr(tmac), .frame_type(ftype),
    .fifo_data_length(flen), .busy(busy), .grant(grant), .done(done), .err(err));

  eth_tx_sched #(.IFG_CYCLES(IFG), .START_TIMEOUT(TO), .PERIOD_CYCLES(100), .CNT_W(32)) u_tmr (
    .gmii_tx_clk(clk), .rst_n(rst_n), .sched_en(t_en),
    .req0(1'b0), .tgt_mac0(48'h0), .type0(16'h0), .len0(16'h0),
    .req1(1'b0), .tgt_mac1(48'h0A0B_0C0D_0E0F), .type1(16'h0806), .len1(16'd28),
    .gmii_tx_en(1'b0), .tx_en(t_tx_en), .target_mac_addr(t_mac), .frame_type(t_type),
    .fifo_data_length(t_len), .busy(t_busy), .grant(t_grant), .done(t_done), .err(t_err));

  typedef struct { int unsigned cyc; logic p; logic [47:0] mac; logic [15:0] ty; logic [15:0] ln; } launch_t;
  typedef struct { int unsigned cyc; logic [1:0] v; } ev_t;
  launch_t exp_l[$];
  ev_t exp_d[$];
  int unsigned exp_e[$];
  int sq[$];
  int n_cmp = 0, n_bad = 0, fixed_n = -1;
  int unsigned cyc = 0, m_free = 0, m_l = 0;
  logic [1:0] m_pend = 0;
  logic m_g = 1, m_en = 0, mon_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic miss(input string name, input int unsigned want_cyc);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected at cycle %0d, not seen by cycle %0d", name, want_cyc, cyc);
  endtask

  // Reference model: pending set/clear, round-robin pick, and the frame timeline
  // tx_en at L, done at L+3+N (sender high L+2..L+1+N), err at L+1+TO, idle again after the gap.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_pend = 0; m_g = 1; m_en = 0; m_free = 0; m_l = 0;
      exp_l.delete(); exp_d.delete(); exp_e.delete(); sq.delete();
    end else begin : model
      logic [1:0] clr;
      launch_t e;
      ev_t d;
      int n;
      clr = 2'b00;
      if (cyc >= m_free && m_en && m_pend != 2'b00) begin
        e.p = (m_pend == 2'b11) ? ~m_g : m_pend[1];
        m_g = e.p;
        clr = e.p ? 2'b10 : 2'b01;
        e.cyc = cyc + 1;
        e.mac = e.p ? mac1 : mac0;
        e.ty = e.p ? type1 : type0;
        e.ln = e.p ? len1 : len0;
        n = (fixed_n >= 0) ? fixed_n : (($urandom % 10 == 0) ? 0 : 1 + int'($urandom % 40));
        sq.push_back(n);
        exp_l.push_back(e);
        m_l = e.cyc;
        if (n > 0) begin
          d.cyc = e.cyc + 3 + n;
          d.v = e.p ? 2'b10 : 2'b01;
          exp_d.push_back(d);
          m_free = e.cyc + 3 + n + IFG;
        end else begin
          exp_e.push_back(e.cyc + 1 + TO);
          m_free = e.cyc + 1 + TO + IFG;
        end
      end
      m_pend = (m_pend & ~clr) | {req1, req0};
      m_en = sched_en;
    end
    cyc++;
  end

  // Sender model: raises gmii_tx_en two cycles after tx_en for the frame length the model chose.
  int s_d = 0, s_n = 0, s_r = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_en) begin
      s_n = (sq.size() > 0) ? sq.pop_front() : 5;
      s_d = 2;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      s_d = 0; s_r = 0; gmii = 0;
    end else begin
      if (gmii) begin
        s_r--;
        if (s_r == 0) gmii = 0;
      end
      if (s_d > 0) begin
        s_d--;
        if (s_d == 0 && s_n > 0) begin
          gmii = 1;
          s_r = s_n;
        end
      end
    end
  end

  launch_t last;
  initial forever begin
    @(negedge clk);
    if (rst_n && mon_on) begin
      if (exp_l.size() > 0 && exp_l[0].cyc < cyc) miss("launch_missing", exp_l.pop_front().cyc);
      if (exp_d.size() > 0 && exp_d[0].cyc < cyc) miss("done_missing", exp_d.pop_front().cyc);
      if (exp_e.size() > 0 && exp_e[0] < cyc) miss("err_missing", exp_e.pop_front());
      if (tx_en) begin
        if (exp_l.size() == 0) chk("launch_extra", 1, 0);
        else begin
          last = exp_l.pop_front();
          chk("launch_cycle", cyc, last.cyc);
          chk("grant", grant, last.p);
          chk("target_mac", tmac, last.mac);
          chk("frame_type", ftype, last.ty);
          chk("length", flen, last.ln);
        end
      end
      if (done != 2'b00) begin
        if (exp_d.size() == 0) chk("done_extra", done, 0);
        else begin
          chk("done_cycle", cyc, exp_d[0].cyc);
          chk("done_value", done, exp_d.pop_front().v);
          chk("hold_mac", tmac, last.mac);
          chk("hold_len", flen, last.ln);
        end
      end
      if (err) begin
        if (exp_e.size() == 0) chk("err_extra", 1, 0);
        else chk("err_cycle", cyc, exp_e.pop_front());
      end
      chk("busy", busy, (cyc >= m_l && cyc < m_free));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_en"}, tx_en, 0);
    chk({tag, "_mac"}, tmac, 0);
    chk({tag, "_type"}, ftype, 0);
    chk({tag, "_len"}, flen, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (cyc >= m_free && m_pend == 0 && !busy && exp_l.size() == 0 && exp_d.size() == 0 && exp_e.size() == 0) break;
      tick();
    end
    if (k == 3000) miss("wait_idle_timeout", cyc);
    repeat (2) tick();
  endtask

  task automatic pulse(input logic p0, input logic p1);
    req0 = p0;
    req1 = p1;
    tick();
    req0 = 0;
    req1 = 0;
  endtask

  initial begin
    int cnt;
    repeat (2) tick();
    check_reset("rst");
    chk("tmr_rst_grant", t_grant, 1);
    chk("tmr_rst_busy", t_busy, 0);
    rst_n = 1;
    // Timer: two wraps while disabled merge into one port-1 frame launched two cycles after enable.
    repeat (250) tick();
    t_en = 1;
    cnt = 0;
    for (int c = 250; c < 299; c++) begin
      @(negedge clk);
      if (t_tx_en) begin
        cnt++;
        chk("tmr_launch_cycle", c, 252);
        chk("tmr_grant", t_grant, 1);
        chk("tmr_mac", t_mac, 48'h0A0B_0C0D_0E0F);
        chk("tmr_len", t_len, 28);
      end
      tick();
    end
    chk("tmr_frames", cnt, 1);
    t_en = 0;
    mon_on = 1;
    sched_en = 1;
    mac0 = 48'h0011_2233_4455; type0 = 16'h0806; len0 = 16'd28;
    mac1 = 48'hFFFF_FFFF_FFFF; type1 = 16'h0806; len1 = 16'd28;
    fixed_n = 27;
    pulse(1, 0);
    wait_idle();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    fixed_n = 10;
    pulse(1, 1);
    wait_idle();
    fixed_n = 5;
    req0 = 1; req1 = 1;
    repeat (150) tick();
    req0 = 0; req1 = 0;
    wait_idle();
    fixed_n = 0;
    pulse(0, 1);
    wait_idle();
    // Asynchronous reset while the sender is mid-frame.
    fixed_n = 30;
    pulse(1, 0);
    for (int k = 0; k < 50 && !gmii; k++) tick();
    repeat (3) tick();
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check_reset("midrst");
    repeat (2) tick();
    rst_n = 1;
    fixed_n = 8;
    mac0 = 48'h0200_0000_0001; len0 = 16'd1;
    pulse(1, 0);
    wait_idle();
    fixed_n = -1;
    for (int i = 0; i < 4000; i++) begin
      req0 = ($urandom % 16 == 0);
      req1 = ($urandom % 16 == 0);
      mac0 = {16'($urandom), 32'($urandom)};
      mac1 = {16'($urandom), 32'($urandom)};
      type0 = 16'($urandom); type1 = 16'($urandom);
      len0 = ($urandom % 4 == 0) ? 16'($urandom % 2) : 16'($urandom);
      len1 = ($urandom % 4 == 0) ? 16'($urandom % 2) : 16'($urandom);
      if ($urandom % 200 == 0) sched_en = ~sched_en;
      tick();
    end
    req0 = 0; req1 = 0; sched_en = 1;
    wait_idle();
    chk("left_launch", exp_l.size(), 0);
    chk("left_done", exp_d.size(), 0);
    chk("left_err", exp_e.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
